// File: rtl/status_scroller_pkg.sv
// status_scroller_pkg: gate-status codes, 5-bit display character set and scroller states.
package status_scroller_pkg;

    localparam logic [2:0] ST_CLOSED          = 3'd0;
    localparam logic [2:0] ST_OPEN            = 3'd1;
    localparam logic [2:0] ST_IDLE            = 3'd2;
    localparam logic [2:0] ST_ENTER_PASSWORD  = 3'd3;
    localparam logic [2:0] ST_CHANGE_PASSWORD = 3'd4;
    localparam logic [2:0] ST_LOCKING         = 3'd5;

    localparam logic [4:0] CHAR_0 = 5'd0;
    localparam logic [4:0] CHAR_1 = 5'd1;
    localparam logic [4:0] CHAR_2 = 5'd2;
    localparam logic [4:0] CHAR_3 = 5'd3;
    localparam logic [4:0] CHAR_4 = 5'd4;
    localparam logic [4:0] CHAR_5 = 5'd5;
    localparam logic [4:0] CHAR_6 = 5'd6;
    localparam logic [4:0] CHAR_7 = 5'd7;
    localparam logic [4:0] CHAR_8 = 5'd8;
    localparam logic [4:0] CHAR_9 = 5'd9;
    localparam logic [4:0] CHAR_A = 5'd10;
    localparam logic [4:0] CHAR_C = 5'd11;
    localparam logic [4:0] CHAR_D = 5'd12;
    localparam logic [4:0] CHAR_E = 5'd13;
    localparam logic [4:0] CHAR_I = 5'd14;
    localparam logic [4:0] CHAR_K = 5'd15;
    localparam logic [4:0] CHAR_L = 5'd16;
    localparam logic [4:0] CHAR_N = 5'd17;
    localparam logic [4:0] CHAR_O = 5'd18;
    localparam logic [4:0] CHAR_P = 5'd19;
    localparam logic [4:0] CHAR_R = 5'd20;
    localparam logic [4:0] CHAR_S = 5'd21;
    localparam logic [4:0] CHAR_T = 5'd22;
    localparam logic [4:0] CHAR_W = 5'd23;
    localparam logic [4:0] CHAR_BLANK = 5'h1F;

    localparam logic [19:0] BLANK_WINDOW = {4{CHAR_BLANK}};

    typedef enum logic [1:0] {LOAD, SHIFT, DONE, HOLD} scrollState_t;

endpackage

// File: rtl/status_scroller_if.sv
// status_scroller_if: status input and display-side outputs of the scroller.
interface status_scroller_if;
    logic [2:0]  gateStatus;
    logic [19:0] displayChars;
    logic        finishedScrolling;
    logic        scrolling;

    modport master (output gateStatus, input displayChars, finishedScrolling, scrolling);
    modport slave  (input gateStatus, output displayChars, finishedScrolling, scrolling);
endinterface

// File: rtl/status_scroller_msg_rom.sv
// status_scroller_msg_rom: per-status message text and length, one character per position.
module status_scroller_msg_rom
    import status_scroller_pkg::*;
(
    input  logic [2:0] status,
    input  logic [4:0] pos,
    output logic [4:0] charCode,
    output logic [3:0] len
);
    logic [39:0] msg;

    // Messages are left-aligned in 8 slots; unused slots stay blank.
    always_comb begin
        msg = {8{CHAR_BLANK}};
        len = 4'd0;
        case (status)
            ST_CLOSED: begin
                msg = {CHAR_C, CHAR_L, CHAR_O, CHAR_S, CHAR_E, CHAR_D, CHAR_BLANK, CHAR_BLANK};
                len = 4'd6;
            end
            ST_OPEN: begin
                msg = {CHAR_O, CHAR_P, CHAR_E, CHAR_N, {4{CHAR_BLANK}}};
                len = 4'd4;
            end
            ST_IDLE: begin
                msg = {CHAR_I, CHAR_D, CHAR_L, CHAR_E, {4{CHAR_BLANK}}};
                len = 4'd4;
            end
            ST_ENTER_PASSWORD: begin
                msg = {CHAR_E, CHAR_N, CHAR_T, CHAR_E, CHAR_R, {3{CHAR_BLANK}}};
                len = 4'd5;
            end
            ST_CHANGE_PASSWORD: begin
                msg = {CHAR_N, CHAR_E, CHAR_W, CHAR_BLANK, CHAR_C, CHAR_O, CHAR_D, CHAR_E};
                len = 4'd8;
            end
            ST_LOCKING: begin
                msg = {CHAR_L, CHAR_O, CHAR_C, CHAR_K, {4{CHAR_BLANK}}};
                len = 4'd4;
            end
            default: ;
        endcase
        charCode = (pos < {1'b0, len}) ? msg[35 - 5 * pos[2:0] +: 5] : CHAR_BLANK;
    end
endmodule

// File: rtl/status_scroller.sv
// status_scroller: scrolls the latched gate-status message right-to-left through a 4-char window
// and pulses finishedScrolling once at the end of a one-shot message.
module status_scroller
    import status_scroller_pkg::*;
#(
    parameter int         TICK_DIV     = 50_000_000,
    parameter logic [5:0] ONESHOT_MASK = 6'b000001
) (
    input logic clk,
    input logic rst,
    status_scroller_if.slave bus
);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [7:0] ONESHOT = {2'b00, ONESHOT_MASK};

    scrollState_t state, stateNext;
    logic [2:0]    latched, latchedNext, romStatus;
    logic [DW-1:0] divider, dividerNext;
    logic [4:0]    pos, posNext, nextChar;
    logic [3:0]    len;
    logic [19:0]   window, windowNext;
    logic          finished, finishedNext, tick, lastStep;

    // LOAD sizes the new message from the live input, every other state from the latched one.
    assign romStatus = (state == LOAD) ? bus.gateStatus : latched;

    status_scroller_msg_rom rom (.status(romStatus), .pos(pos), .charCode(nextChar), .len(len));

    assign tick     = divider == DIV_LAST;
    assign lastStep = pos == {1'b0, len} + 5'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            latched  <= 3'd7;
            divider  <= '0;
            pos      <= 5'd0;
            window   <= BLANK_WINDOW;
            finished <= 1'b0;
        end else begin
            state    <= stateNext;
            latched  <= latchedNext;
            divider  <= dividerNext;
            pos      <= posNext;
            window   <= windowNext;
            finished <= finishedNext;
        end
    end

    // A status change outranks everything, including the final step of a one-shot pass.
    always_comb begin
        stateNext    = state;
        latchedNext  = latched;
        dividerNext  = divider;
        posNext      = pos;
        windowNext   = window;
        finishedNext = 1'b0;
        if (state == LOAD) begin
            latchedNext = bus.gateStatus;
            windowNext  = BLANK_WINDOW;
            posNext     = 5'd0;
            dividerNext = '0;
            stateNext   = (len != 4'd0) ? SHIFT : HOLD;
        end else if (bus.gateStatus != latched) begin
            stateNext = LOAD;
        end else if (state == SHIFT) begin
            dividerNext = tick ? '0 : divider + 1'b1;
            if (tick) begin
                windowNext = {window[14:0], nextChar};
                posNext    = lastStep ? 5'd0 : pos + 5'd1;
                if (lastStep && ONESHOT[latched]) begin
                    stateNext    = DONE;
                    finishedNext = 1'b1;
                end
            end
        end
    end

    assign bus.displayChars      = window;
    assign bus.finishedScrolling = finished;
    assign bus.scrolling         = state == SHIFT;
endmodule
